// File: rtl/slave_port.sv
// slave_port: serial-bus slave endpoint; deserialises address/data frames and performs one
// access on a local parallel memory port. Optional read timeout: define SLAVE_RD_TIMEOUT_EN.
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  smemrvalid
);

  // state | meaning
  // IDLE  | waiting for the first frame bit
  // ADDR  | shifting in address bits 1..ADDR_WIDTH-1
  // WDATA | shifting in write data bits
  // WRITE | one-cycle memory write strobe
  // READ  | one-cycle memory read request
  // RWAIT | waiting for smemrvalid (or timeout)
  // RDATA | streaming read data out, LSB first
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, READ, RWAIT, RDATA} state_e;

  localparam int MAX_LEN = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rshift_q, rshift_d;
  logic                  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;
  logic                  sready_q, sready_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;

`ifdef SLAVE_RD_TIMEOUT_EN
  localparam int TMO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(RD_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rshift_d = rshift_q;
    srdata_d = 1'b0;
`ifdef SLAVE_RD_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (mvalid) begin
          addr_d  = {swdata, addr_q[ADDR_WIDTH-1:1]};
          mode_d  = smode;
          cnt_d   = CNT_ONE;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (mvalid) begin
          addr_d = {swdata, addr_q[ADDR_WIDTH-1:1]};
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? WDATA : READ;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      WDATA: begin
        if (mvalid) begin
          wdata_d = {swdata, wdata_q[DATA_WIDTH-1:1]};
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ: begin
        state_d = RWAIT;
`ifdef SLAVE_RD_TIMEOUT_EN
        tmo_d   = TMO_LOAD;
`endif
      end
      RWAIT: begin
        // the first output bit is launched on the capture edge so svalid runs gap-free
        if (smemrvalid) begin
          srdata_d = smemrdata[0];
          rshift_d = {1'b0, smemrdata[DATA_WIDTH-1:1]};
          state_d  = RDATA;
`ifdef SLAVE_RD_TIMEOUT_EN
        end else if (tmo_q == '0) begin
          srdata_d = 1'b1;
          rshift_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
          state_d  = RDATA;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
`endif
        end
      end
      RDATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + CNT_ONE;
          srdata_d = rshift_q[0];
          rshift_d = {1'b0, rshift_q[DATA_WIDTH-1:1]};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sready_d = (state_d == IDLE);
  assign svalid_d = (state_d == RDATA);
  assign wen_d    = (state_d == WRITE);
  assign ren_d    = (state_d == READ);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rshift_q <= '0;
      srdata_q <= 1'b0;
      svalid_q <= 1'b0;
      sready_q <= 1'b1;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rshift_q <= rshift_d;
      srdata_q <= srdata_d;
      svalid_q <= svalid_d;
      sready_q <= sready_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
    end
  end

`ifdef SLAVE_RD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign srdata    = srdata_q;
  assign svalid    = svalid_q;
  assign sready    = sready_q;
  assign smemaddr  = addr_q;
  assign smemwdata = wdata_q;
  assign smemwen   = wen_q;
  assign smemren   = ren_q;

endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: table-driven frames with a scoreboard of expected memory strobes and
// read responses, plus hand-written reset-abort and read-timeout sequences.
`timescale 1ns/1ps
module tb_slave_port;
  localparam int AW     = 12;
  localparam int DW     = 8;
  localparam int RD_TMO = 16;

  logic          clk = 1'b0;
  logic          rstn, swdata, smode, mvalid;
  logic          srdata, svalid, sready, smemwen, smemren, smemrvalid;
  logic [AW-1:0] smemaddr;
  logic [DW-1:0] smemwdata, smemrdata;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(RD_TMO)) dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready),
    .smemaddr(smemaddr), .smemwdata(smemwdata), .smemwen(smemwen), .smemren(smemren),
    .smemrdata(smemrdata), .smemrvalid(smemrvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          gap_a_pos, gap_a_len, gap_d_pos, gap_d_len;
    int          lat;     // 0: memory never answers
    bit          early;   // spurious smemrvalid during READ
    bit          junk;    // mvalid held high in the cycle after the last bit
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          strobe_cyc;
    int          rsp_cyc;
  } exp_t;

  exp_t          sb_q[$];
  vec_t          vecs[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            ncyc = 0;
  int            ready_chk_cyc = -1;
  int            nbit = 0;
  int            first_sv = 0;
  int            sv_total = 0;
  logic [DW-1:0] rword = '0;
  logic [DW-1:0] last_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, ncyc);
    end
  endtask

  function automatic vec_t mk(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int gap, int gl,
                              int gdp, int gdl, int lat, bit early, bit junk, logic [DW-1:0] ex);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d;
    v.gap_a_pos = gap; v.gap_a_len = gl; v.gap_d_pos = gdp; v.gap_d_len = gdl;
    v.lat = lat; v.early = early; v.junk = junk; v.exp_data = ex;
    return v;
  endfunction

  // scoreboard consumer: every strobe and every completed response must match the queue head
  always @(negedge clk) begin : monitor
    exp_t e;
    ncyc++;
    if (ncyc == ready_chk_cyc) check("sready_back_high", 32'(sready), 32'd1);
    if (smemwen) begin
      check("wen_expected", 32'(sb_q.size() > 0 && sb_q[0].wr), 32'd1);
      if (sb_q.size() > 0 && sb_q[0].wr) begin
        e = sb_q.pop_front();
        check("wen_addr", 32'(smemaddr), 32'(e.addr));
        check("wen_data", 32'(smemwdata), 32'(e.data));
        check("wen_cycle", ncyc, e.strobe_cyc);
        ready_chk_cyc = ncyc + 1;
      end
      check("sready_low_wen", 32'(sready), 32'd0);
    end
    if (smemren) begin
      check("ren_expected", 32'(sb_q.size() > 0 && !sb_q[0].wr), 32'd1);
      if (sb_q.size() > 0 && !sb_q[0].wr) begin
        check("ren_addr", 32'(smemaddr), 32'(sb_q[0].addr));
        check("ren_cycle", ncyc, sb_q[0].strobe_cyc);
      end
    end
    if (svalid) begin
      sv_total++;
      if (nbit == 0) begin
        first_sv = ncyc;
        check("sready_low_rsp", 32'(sready), 32'd0);
      end
      if (nbit < DW) rword[nbit] = srdata;
      nbit++;
      if (nbit == DW) begin
        check("rsp_expected", 32'(sb_q.size() > 0 && !sb_q[0].wr), 32'd1);
        if (sb_q.size() > 0 && !sb_q[0].wr) begin
          e = sb_q.pop_front();
          check("rsp_data", 32'(rword), 32'(e.data));
          check("rsp_cycle", first_sv, e.rsp_cyc);
          ready_chk_cyc = ncyc + 1;
        end
        nbit = 0;
      end
    end else if (nbit != 0) begin
      check("svalid_run_len", nbit, DW);
      nbit = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    bit   mv[$];
    bit   bt[$];
    int   last_addr_idx;
    int   last_data_idx;
    bit   seen;
    exp_t e;
    last_addr_idx = -1;
    last_data_idx = -1;
    seen = 1'b0;
    for (int k = 0; k < AW; k++) begin
      mv.push_back(1'b1);
      bt.push_back(v.addr[k]);
      if (k == AW - 1) last_addr_idx = mv.size() - 1;
      if (k == v.gap_a_pos) repeat (v.gap_a_len) begin mv.push_back(1'b0); bt.push_back(1'b0); end
    end
    if (v.wr) begin
      for (int k = 0; k < DW; k++) begin
        mv.push_back(1'b1);
        bt.push_back(v.data[k]);
        if (k == DW - 1) last_data_idx = mv.size() - 1;
        if (k == v.gap_d_pos) repeat (v.gap_d_len) begin mv.push_back(1'b0); bt.push_back(1'b0); end
      end
    end
    for (int i = 0; i < mv.size(); i++) begin
      mvalid = mv[i];
      swdata = mv[i] ? bt[i] : i[0];
      smode  = (i == 0) ? v.wr : ~v.wr;
      e.wr = v.wr; e.addr = v.addr; e.data = v.exp_data;
      if (i == last_addr_idx && !v.wr) begin
        e.strobe_cyc = ncyc + 2;
        e.rsp_cyc    = ncyc + 2 + ((v.lat > 0) ? v.lat : RD_TMO) + 1;
        sb_q.push_back(e);
      end
      if (i == last_data_idx && v.wr) begin
        e.strobe_cyc = ncyc + 2;
        e.rsp_cyc    = 0;
        sb_q.push_back(e);
        last_wdata   = v.exp_data;
      end
      @(negedge clk);
      if (i == 0) check("sready_idle_first_bit", 32'(sready), 32'd1);
      if (i == 1) check("sready_fall", 32'(sready), 32'd0);
      @(posedge clk);
      #1;
    end
    mvalid = v.junk;
    swdata = 1'b1;
    smode  = 1'b0;
    if (v.wr) begin
      step();
      mvalid = 1'b0;
    end else begin
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        seen = smemren;
      end
      check("ren_seen", 32'(seen), 32'd1);
      if (seen && v.early) begin
        smemrvalid = 1'b1;
        smemrdata  = ~v.data;
      end
      @(posedge clk);
      #1;
      mvalid = 1'b0;
      smemrvalid = 1'b0;
      if (seen && v.lat > 0) begin
        repeat (v.lat - 1) step();
        smemrvalid = 1'b1;
        smemrdata  = v.data;
        step();
        smemrvalid = 1'b0;
        smemrdata  = 8'h3C;
      end
    end
  endtask

  task automatic drain(input logic [AW-1:0] exp_addr);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || nbit != 0 || !sready) && k < 200) begin
      step();
      k++;
    end
    check("drain_done", 32'(k < 200), 32'd1);
    step();
    check("addr_hold", 32'(smemaddr), 32'(exp_addr));
    check("wdata_hold", 32'(smemwdata), 32'(last_wdata));
    sb_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sv_before;
    vecs.push_back(mk(1'b1, 12'h234, 8'hAA, -1, 0, -1, 0, 0, 1'b0, 1'b0, 8'hAA));
    vecs.push_back(mk(1'b1, 12'h234, 8'hAA,  5, 3,  2, 3, 0, 1'b0, 1'b0, 8'hAA));
    vecs.push_back(mk(1'b0, 12'h0F0, 8'h5C, -1, 0, -1, 0, 3, 1'b0, 1'b0, 8'h5C));
    vecs.push_back(mk(1'b0, 12'hFFF, 8'h81, -1, 0, -1, 0, 1, 1'b0, 1'b1, 8'h81));
    vecs.push_back(mk(1'b1, 12'hFFF, 8'hFF, 11, 4,  0, 1, 0, 1'b0, 1'b1, 8'hFF));
    vecs.push_back(mk(1'b1, 12'h000, 8'h00,  0, 2, -1, 0, 0, 1'b0, 1'b0, 8'h00));
    vecs.push_back(mk(1'b0, 12'h555, 8'hA5,  0, 2, -1, 0, 5, 1'b1, 1'b0, 8'hA5));
    vecs.push_back(mk(1'b1, 12'hABC, 8'h3C,  3, 1,  6, 2, 0, 1'b0, 1'b0, 8'h3C));
`ifndef SLAVE_RD_TIMEOUT_EN
    vecs.push_back(mk(1'b0, 12'h321, 8'h6E, -1, 0, -1, 0, 40, 1'b0, 1'b0, 8'h6E));
`endif

    // reset with mvalid asserted: nothing may be captured
    rstn = 1'b0; mvalid = 1'b1; swdata = 1'b1; smode = 1'b1;
    smemrvalid = 1'b0; smemrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    mvalid = 1'b0;
    @(negedge clk);
    check("rst_sready", 32'(sready), 32'd1);
    check("rst_svalid", 32'(svalid), 32'd0);
    check("rst_srdata", 32'(srdata), 32'd0);
    check("rst_wen", 32'(smemwen), 32'd0);
    check("rst_ren", 32'(smemren), 32'd0);
    check("rst_addr", 32'(smemaddr), 32'd0);
    check("rst_wdata", 32'(smemwdata), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i]);
      drain(vecs[i].addr);
    end

    // abort a write after seven address bits
    for (int k = 0; k < 7; k++) begin
      mvalid = 1'b1; swdata = 1'b1; smode = 1'b1;
      step();
    end
    mvalid = 1'b0;
    rstn = 1'b0;
    step();
    step();
    check("abort_sready", 32'(sready), 32'd1);
    check("abort_addr", 32'(smemaddr), 32'd0);
    last_wdata = '0;
    rstn = 1'b1;
    repeat (3) step();
    run_frame(mk(1'b1, 12'h001, 8'h01, -1, 0, -1, 0, 0, 1'b0, 1'b0, 8'h01));
    drain(12'h001);

`ifdef SLAVE_RD_TIMEOUT_EN
    // memory never answers: all-ones after the timeout, late smemrvalid ignored
    run_frame(mk(1'b0, 12'h123, 8'h00, -1, 0, -1, 0, 0, 1'b0, 1'b0, 8'hFF));
    for (int k = 0; k < 40 && !svalid; k++) @(negedge clk);
    @(posedge clk);
    #1;
    smemrvalid = 1'b1;
    smemrdata  = 8'h00;
    step();
    smemrvalid = 1'b0;
    drain(12'h123);
    sv_before = sv_total;
    smemrvalid = 1'b1;
    step();
    smemrvalid = 1'b0;
    repeat (12) step();
    check("late_rvalid_ignored", sv_total - sv_before, 0);
    check("late_sready", 32'(sready), 32'd1);
`else
    sv_before = sv_total;
    repeat (4) step();
    check("idle_no_svalid", sv_total - sv_before, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slave_port.md
# slave_port

Serial-bus slave endpoint that terminates frames driven by a master port once the arbiter has granted it the bus. It deserialises the address and, for writes, the data. It then performs one access on a local parallel memory interface. For reads, it serialises the returned data back to the master with a valid strobe.

## Interface
- ADDR_WIDTH, 12: local word address bits carried in the serial frame.
- DATA_WIDTH, 8: data word width.
- RD_TIMEOUT, 16: read-wait cycle limit; used only with SLAVE_RD_TIMEOUT_EN.

- clk  input  1  single clock; all logic on rising edge.
- rstn  input  1  synchronous, active-low reset.
- swdata  input  1  serial write data from bus (address, then data, LSB first).
- smode  input  1  0 = read, 1 = write; sampled on the first frame bit.
- mvalid  input  1  swdata bit valid this cycle.
- srdata  output  1  serial read data to bus, LSB first.
- svalid  output  1  srdata bit valid this cycle.
- sready  output  1  1 = idle, able to accept a new frame.
- smemaddr  output  ADDR_WIDTH  memory address.
- smemwdata  output  DATA_WIDTH  memory write data.
- smemwen  output  1  one-cycle write strobe.
- smemren  output  1  one-cycle read request strobe.
- smemrdata  input  DATA_WIDTH  memory read data.
- smemrvalid  input  1  smemrdata valid; variable latency ≥1 cycle after smemren.

## Operation
- States: IDLE, ADDR, WDATA, WRITE, READ, RWAIT, RDATA.
- IDLE: sready=1. A rising edge with mvalid=1 captures swdata as address bit 0, latches smode, sets the bit counter to 1, and moves to ADDR.
- ADDR: each edge with mvalid=1 shifts in the next address bit. Cycles with mvalid=0 are gaps: hold state and counter. After ADDR_WIDTH bits, go to WDATA if the mode is write, else READ.
- WDATA: same gap rule, shifts DATA_WIDTH bits into smemwdata. Then go to WRITE.
- WRITE: smemwen=1 for exactly one cycle, then IDLE.
- READ: smemren=1 for exactly one cycle, then RWAIT.
- RWAIT: on the first edge with smemrvalid=1, capture smemrdata into the shift register and go to RDATA. smemrvalid during READ is ignored.
- RDATA: svalid=1 for DATA_WIDTH consecutive cycles. srdata carries the captured bit 0 first, then higher bits. Then IDLE.
- mvalid is ignored in WRITE, READ, RWAIT and RDATA; bits arriving there are dropped.
- Counter width is clog2(max(ADDR_WIDTH, DATA_WIDTH)+1). It resets to 0 on every phase change. There is no wrap beyond the phase length.
- smemaddr and smemwdata hold their last values between frames.

## Timing
- Reset values: sready=1, svalid=0, srdata=0, smemwen=0, smemren=0, smemaddr=0, smemwdata=0; state IDLE, counter 0.
- rstn=0 sampled in any state aborts the frame on that edge. No memory strobe is issued after that edge.
- All outputs are registered.
- sready falls in the cycle after the first frame bit is sampled. It rises in the cycle after the last WRITE or RDATA cycle.
- Write latency: smemwen is high in the cycle immediately after the edge that samples the last data bit. Gapless write frame: ADDR_WIDTH+DATA_WIDTH bit cycles + 1 strobe cycle, then idle.
- Read latency: smemren is high in the cycle after the last address bit. The first svalid cycle is the cycle after the edge sampling smemrvalid=1. A memory latency of L gives ADDR_WIDTH + 1 + L + DATA_WIDTH cycles from first bit to last svalid.
- svalid never has gaps within a read response.

## Configuration
- SLAVE_RD_TIMEOUT_EN defined: an RWAIT cycle counter is cleared on entry. If RD_TIMEOUT edges pass without smemrvalid, the block captures all-ones and enters RDATA. smemrvalid arriving later, in RDATA or IDLE, is ignored.
- SLAVE_RD_TIMEOUT_EN undefined: RWAIT waits indefinitely. No timeout counter is synthesised.

## Test plan
- Reset: hold rstn=0 for 3 edges -> sready=1; svalid, smemwen and smemren are 0; smemaddr=0.
- Gapless write, addr 12'h234, data 8'hAA, smode=1 -> after 20 bits, exactly one cycle of smemwen with smemaddr=12'h234 and smemwdata=8'hAA; sready high in the next cycle.
- Write with mvalid gaps (mvalid=0 for 3 cycles after address bit 5 and after data bit 2) -> same result as the gapless write; strobe delayed by 6 cycles.
- Read, addr 12'h0F0, memory returns 8'h5C with L=3 -> smemren for one cycle with smemaddr=12'h0F0; then 8 consecutive svalid cycles with srdata=0,0,1,1,1,0,1,0.
- Reset mid-frame: rstn=0 after 7 address bits, release, then send a full write to 12'h001 with data 8'h01 -> no strobe from the aborted frame; exactly one write to 12'h001.
- With SLAVE_RD_TIMEOUT_EN, RD_TIMEOUT=16 and smemrvalid never asserted -> after 16 RWAIT cycles, 8 svalid cycles of srdata=1, then sready=1; a late smemrvalid pulse produces no further svalid.
